// File: rtl/led_debug_pager.sv
// led_debug_pager: pages probe words onto board LEDs with live/freeze/sticky/walking-one modes
module led_debug_pager #(
  parameter int LED_W           = 16,
  parameter int N_PAGES         = 8,
  parameter int SEL_W           = $clog2(N_PAGES),
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_CYCLES     = 50_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PAGES*LED_W-1:0]   page_data,
  input  logic [SEL_W-1:0]           sel_sw,
  input  logic [1:0]                 mode_sw,
  input  logic                       btn_next,
  input  logic                       btn_clear,
  output logic [LED_W-1:0]           led,
  output logic [SEL_W-1:0]           page_idx,
  output logic                       heartbeat
);
  localparam int AW = SEL_W + 4;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TICK_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_PAGES - 1);
  logic [SYNC_STAGES*AW-1:0] sr;
  logic [SEL_W-1:0] sel_s, sel_prev, idx_prev;
  logic [1:0] mode_s, mode_prev, btn_s, deb, pulse;
  logic [DW-1:0] dcnt [2];
  logic [TW-1:0] tcnt;
  logic tick, reload;
  logic [LED_W-1:0] cur, snap, stk, walk, snap_n, stk_n, walk_n;
  assign {sel_s, mode_s, btn_s} = sr[SYNC_STAGES*AW-1 -: AW];
  assign tick = tcnt == TMAX;
  assign cur = page_data[page_idx*LED_W +: LED_W];
  // next values for the mode registers; a reload takes the current word outright
  always_comb begin
    reload = (mode_s != mode_prev) || (page_idx != idx_prev) || pulse[1];
    snap_n = reload ? cur : snap;
    stk_n  = reload ? cur : (stk | cur);
    walk_n = (mode_prev != 2'b11) ? LED_W'(1) : tick ? {walk[LED_W-2:0], walk[LED_W-1]} : walk;
  end
  // all asynchronous switches and buttons share one synchroniser shift chain
  always_ff @(posedge clk)
    sr <= rst ? '0 : {sr[(SYNC_STAGES-1)*AW-1:0], sel_sw, mode_sw, btn_clear, btn_next};
  // debouncers: state flips after DEBOUNCE_CYCLES of disagreement; pulse only on the rising flip
  always_ff @(posedge clk)
    if (rst) begin
      deb <= '0;
      pulse <= '0;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else
      for (int i = 0; i < 2; i++) begin
        pulse[i] <= 1'b0;
        if (btn_s[i] == deb[i]) dcnt[i] <= '0;
        else if (dcnt[i] == DMAX) begin
          deb[i] <= ~deb[i];
          dcnt[i] <= '0;
          pulse[i] <= ~deb[i];
        end else dcnt[i] <= dcnt[i] + 1'b1;
      end
  // page selection, tick/heartbeat and the per-mode LED registers
  always_ff @(posedge clk)
    if (rst) begin
      sel_prev <= '0;
      mode_prev <= '0;
      idx_prev <= '0;
      page_idx <= '0;
      tcnt <= '0;
      heartbeat <= 1'b0;
      snap <= '0;
      stk <= '0;
      walk <= LED_W'(1);
      led <= '0;
    end else begin
      sel_prev <= sel_s;
      mode_prev <= mode_s;
      idx_prev <= page_idx;
      tcnt <= tick ? '0 : tcnt + 1'b1;
      heartbeat <= heartbeat ^ tick;
      if (sel_s != sel_prev) page_idx <= (sel_s > LAST) ? LAST : sel_s;
      else if (pulse[0]) page_idx <= (page_idx == LAST) ? '0 : page_idx + 1'b1;
      if (mode_s == 2'b01) snap <= snap_n;
      if (mode_s == 2'b10) stk <= stk_n;
      if (mode_s == 2'b11) walk <= walk_n;
      led <= (mode_s == 2'b00) ? cur : (mode_s == 2'b01) ? snap_n : (mode_s == 2'b10) ? stk_n : walk_n;
    end
endmodule

// File: tb/tb_led_debug_pager.sv
// tb_led_debug_pager: random and directed stimulus checked against a behavioural model
module tb_led_debug_pager;
  localparam int LED_W = 8, N_PAGES = 3, SEL_W = 2, SYNC = 2, DEB = 4, TICK = 5;
  logic clk = 0, rst = 1;
  logic [N_PAGES*LED_W-1:0] page_data = '0;
  logic [SEL_W-1:0] sel_sw = '0;
  logic [1:0] mode_sw = '0;
  logic btn_next = 0, btn_clear = 0;
  logic [LED_W-1:0] led;
  logic [SEL_W-1:0] page_idx;
  logic heartbeat;
  int vectors = 0, miscompares = 0;

  led_debug_pager #(.LED_W(LED_W), .N_PAGES(N_PAGES), .SEL_W(SEL_W), .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TICK)) dut (
    .clk(clk), .rst(rst), .page_data(page_data), .sel_sw(sel_sw), .mode_sw(mode_sw),
    .btn_next(btn_next), .btn_clear(btn_clear), .led(led), .page_idx(page_idx), .heartbeat(heartbeat));

  always #5 clk = ~clk;

  // behavioural model: inputs seen SYNC edges late, buttons by run length, ticks by edge count
  logic [5:0] q[$];
  logic [5:0] s;
  logic started = 0;
  int k, entry, run[2];
  logic [1:0] m_deb, m_pend, prev_mode;
  logic [SEL_W-1:0] prev_sel, m_page, old_page;
  logic moved, m_hb, reload;
  logic [LED_W-1:0] m_led, m_snap, m_stk, cur, w;

  always @(posedge clk) begin
    started <= 1;
    if (rst) begin
      q = '{6'd0, 6'd0};
      k = 0; entry = 0; run[0] = 0; run[1] = 0;
      m_deb = 0; m_pend = 0; prev_mode = 0; prev_sel = 0; m_page = 0;
      moved = 0; m_hb = 0; m_led = 0; m_snap = 0; m_stk = 0;
    end else begin
      s = q.pop_front();
      q.push_back({sel_sw, mode_sw, btn_clear, btn_next});
      k++;
      m_hb = ((k / TICK) % 2) == 1;
      cur = page_data[int'(m_page)*LED_W +: LED_W];
      reload = (s[3:2] != prev_mode) || moved || m_pend[1];
      if (s[3:2] == 2'd0) m_led = cur;
      else if (s[3:2] == 2'd1) begin
        if (reload) m_snap = cur;
        m_led = m_snap;
      end else if (s[3:2] == 2'd2) begin
        m_stk = reload ? cur : (m_stk | cur);
        m_led = m_stk;
      end else begin
        if (prev_mode != 2'd3) entry = k;
        w = 1;
        w = w << ((k / TICK - entry / TICK) % LED_W);
        m_led = w;
      end
      old_page = m_page;
      if (s[5:4] != prev_sel) m_page = (int'(s[5:4]) > N_PAGES - 1) ? SEL_W'(N_PAGES - 1) : s[5:4];
      else if (m_pend[0]) m_page = (int'(m_page) == N_PAGES - 1) ? '0 : m_page + 1'b1;
      moved = m_page != old_page;
      m_pend = 0;
      for (int b = 0; b < 2; b++)
        if (s[b] == m_deb[b]) run[b] = 0;
        else begin
          run[b]++;
          if (run[b] == DEB) begin
            m_deb[b] = ~m_deb[b];
            run[b] = 0;
            m_pend[b] = m_deb[b];
          end
        end
      prev_sel = s[5:4];
      prev_mode = s[3:2];
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk)
    if (started) begin
      vectors++;
      if (led !== m_led || page_idx !== m_page || heartbeat !== m_hb) begin
        miscompares++;
        $display("FAIL model t=%0t: got led=%h idx=%0d hb=%b, expected led=%h idx=%0d hb=%b",
                 $time, led, page_idx, heartbeat, m_led, m_page, m_hb);
      end
    end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [LED_W-1:0] act, input logic [LED_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    page_data = {8'h33, 8'h22, 8'h11};
    cyc(2);
    check("rst_led", led, 8'h00);
    check("rst_idx", LED_W'(page_idx), 8'h00);
    check("rst_hb", LED_W'(heartbeat), 8'h00);
    rst = 0;
    cyc(3);
    check("live_p0", led, 8'h11);
    sel_sw = 2;
    cyc(3);
    check("sel_idx2", LED_W'(page_idx), 8'h02);
    cyc(1);
    check("sel_led33", led, 8'h33);
    sel_sw = 1;
    cyc(4);
    check("sel_idx1", LED_W'(page_idx), 8'h01);
    sel_sw = 3;
    cyc(3);
    check("sel_clamp", LED_W'(page_idx), 8'h02);
    btn_next = 1;
    cyc(7);
    check("next_wrap", LED_W'(page_idx), 8'h00);
    cyc(1);
    check("next_led", led, 8'h11);
    cyc(2);
    btn_next = 0;
    cyc(8);
    check("release_nop", LED_W'(page_idx), 8'h00);
    btn_next = 1;
    cyc(2);
    btn_next = 0;
    cyc(10);
    check("bounce_nop", LED_W'(page_idx), 8'h00);
    sel_sw = 1;
    page_data = {8'h33, 8'hA5, 8'h11};
    cyc(4);
    check("frz_live", led, 8'hA5);
    mode_sw = 2'b01;
    cyc(4);
    page_data = {8'h33, 8'h00, 8'h11};
    cyc(3);
    check("frz_hold", led, 8'hA5);
    btn_clear = 1;
    cyc(7);
    check("frz_clear", led, 8'h00);
    btn_clear = 0;
    cyc(8);
    page_data = {8'h33, 8'h00, 8'h00};
    sel_sw = 0;
    mode_sw = 2'b10;
    cyc(6);
    check("stk_base", led, 8'h00);
    page_data[7:0] = 8'h01;
    cyc(1);
    check("stk_01", led, 8'h01);
    page_data[7:0] = 8'h04;
    cyc(1);
    check("stk_05", led, 8'h05);
    page_data[7:0] = 8'h00;
    cyc(1);
    check("stk_hold", led, 8'h05);
    btn_clear = 1;
    cyc(7);
    check("stk_clear", led, 8'h00);
    btn_clear = 0;
    cyc(8);
    mode_sw = 2'b11;
    cyc(3);
    check("test_entry", led, 8'h01);
    cyc(40);
    check("test_wrap", led, 8'h01);
    page_data = {8'h00, 8'h00, 8'h00};
    sel_sw = 2;
    mode_sw = 2'b10;
    cyc(6);
    page_data[23:16] = 8'h01;
    cyc(1);
    page_data[23:16] = 8'h04;
    cyc(1);
    check("pre_rst_led", led, 8'h05);
    check("pre_rst_idx", LED_W'(page_idx), 8'h02);
    rst = 1;
    sel_sw = 0;
    mode_sw = 0;
    cyc(1);
    check("mid_rst_led", led, 8'h00);
    check("mid_rst_idx", LED_W'(page_idx), 8'h00);
    check("mid_rst_hb", LED_W'(heartbeat), 8'h00);
    rst = 0;
    cyc(10);
    check("no_spurious", LED_W'(page_idx), 8'h00);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(19) == 0) sel_sw = SEL_W'($urandom_range(3));
      if ($urandom_range(29) == 0) mode_sw = 2'($urandom_range(3));
      if ($urandom_range(5) == 0) btn_next = ~btn_next;
      if ($urandom_range(7) == 0) btn_clear = ~btn_clear;
      if ($urandom_range(2) == 0) page_data = (N_PAGES*LED_W)'($urandom);
      if ($urandom_range(3) == 0) page_data = '0;
      rst = $urandom_range(499) == 0;
      cyc(1);
    end
    rst = 0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/led_debug_pager.md
# led_debug_pager

Parametrised board-level status display for the FPGA top. Up to N_PAGES probe words of LED_W bits are paged onto the board LEDs. The selected page is driven from switches or from a debounced "next page" button. Live, freeze, sticky-capture and walking-one test modes replace the fixed 4-page LED mux with its hard-wired test patterns.

## Interface

Parameters:
- LED_W, 16, LED count and width of each probe page.
- N_PAGES, 8, number of probe pages (2..16).
- SEL_W, $clog2(N_PAGES), width of page index and page select switches.
- SYNC_STAGES, 2, flip-flop stages on every asynchronous input (≥2).
- DEBOUNCE_CYCLES, 1_000_000, stable-cycle count required on each button.
- TICK_CYCLES, 50_000_000, period of the internal tick (heartbeat and walking-one).

Ports:
- clk, input, 1, system clock; only clock.
- rst, input, 1, synchronous active-high reset.
- page_data, input, N_PAGES*LED_W, flattened probe words; page p occupies bits [p*LED_W +: LED_W]; synchronous to clk.
- sel_sw, input, SEL_W, page select switches; asynchronous.
- mode_sw, input, 2, mode: 00 live, 01 freeze, 10 sticky, 11 test; asynchronous.
- btn_next, input, 1, page-advance button, active high; asynchronous.
- btn_clear, input, 1, sticky/snapshot clear button, active high; asynchronous.
- led, output, LED_W, registered LED drive.
- page_idx, output, SEL_W, currently selected page, registered.
- heartbeat, output, 1, toggles every tick.

## Operation

Input conditioning:
- sel_sw, mode_sw, btn_next and btn_clear each pass through a SYNC_STAGES synchroniser.
- Each button has a debouncer holding a debounced state and a counter.
  - The counter clears whenever the synced input equals the debounced state.
  - The counter increments otherwise.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced state flips and the counter clears.
- A 0→1 transition of the debounced state produces a one-cycle pulse: next_p or clear_p.

Page selection:
- The synced sel_sw value is compared with its previous-cycle value. On any change, page_idx loads min(sel, N_PAGES-1).
- Otherwise, on next_p, page_idx increments, wrapping from N_PAGES-1 to 0.
- A sel_sw change and next_p in the same cycle: the sel_sw change wins and next_p is dropped.
- `cur` = page_data word at page_idx.
- `reload` = mode change, page_idx change or clear_p, evaluated on the cycle the event is registered.

Modes (synced mode_sw):
- Live: led <= cur.
- Freeze: on reload, snap <= cur; otherwise snap holds. led <= snap.
- Sticky: on reload, stk <= cur; otherwise stk <= stk | cur. led <= stk.
  - Reload and a new set bit in the same cycle: the reload value (cur) is used.
- Test: on entry, walk <= 1 (bit 0). On each tick, walk rotates left (MSB→bit 0). led <= walk. page_data is ignored.
- Snap, stk and walk update only while their own mode is active.

Tick:
- A counter runs 0..TICK_CYCLES-1 in all modes; tick asserts at the wrap.
- heartbeat toggles on each tick.

## Timing

Reset (rst high at a clk edge), applicable mid-operation:
- led = 0, page_idx = 0, heartbeat = 0.
- snap = 0, stk = 0, walk = 1.
- Tick counter, debounce counters and debounced states = 0.
- Synchronisers = 0.
- No next_p or clear_p pulse is generated by reset release.

Latencies:
- page_data → led in live mode: 1 cycle.
- sel_sw → page_idx: SYNC_STAGES+1 cycles; led follows 1 cycle later.
- Button press, held stable → next_p/clear_p: SYNC_STAGES+DEBOUNCE_CYCLES cycles. Release is debounced identically and produces no pulse.
- A bounce shorter than DEBOUNCE_CYCLES produces no state change.
- mode_sw → new led source: SYNC_STAGES+1 cycles.
- Snapshot/sticky reload is visible on led 1 cycle after the reload event.
- First tick occurs TICK_CYCLES cycles after reset release.

## Test plan

Parameters for all scenarios: LED_W=8, N_PAGES=3, DEBOUNCE_CYCLES=4, TICK_CYCLES=5, SYNC_STAGES=2.

- Live paging: page_data = {8'h33, 8'h22, 8'h11}, sel_sw 0→2 → page_idx=2 after 3 cycles; led=8'h33 one cycle later. sel_sw=3 → page_idx clamps to 2.
- Next-button wrap: page_idx=2, btn_next held 10 cycles → single next_p after 6 cycles; page_idx=0, led=8'h11. A 2-cycle pulse on btn_next → no change.
- Freeze: live on page 1 with data 8'hA5, mode→01, then data→8'h00 → led stays 8'hA5. Press clear → led=8'h00.
- Sticky: mode 10 on page 0, data sequence 8'h01, 8'h04, 8'h00 → led 8'h01, 8'h05, 8'h05. clear_p with data 8'h00 → led 8'h00.
- Test/heartbeat: mode 11 → led=8'h01, rotating one bit per 5 cycles. After 8 ticks led=8'h01 again (MSB wraps to bit 0); heartbeat toggles every 5 cycles.
- Reset mid-operation: rst pulsed during sticky with led=8'h05 and page_idx=2 → next cycle led=0, page_idx=0, heartbeat=0; no spurious page advance after release with buttons low.
